hazard_detect_unit: RTL and testbench

HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

---
 rtl/hazard_detect_unit.sv | 108 ++++++++++
 tb/tb_hazard_detect_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detection: load-use and branch-operand stalls, taken-branch flush.
// Zero-latency combinational stall/flush; HAZARD_STATS_EN compiles in a saturating stall counter.
module hazard_detect_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        ID_Taken,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_WriteReg,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_WriteReg,
    output logic        HazardSel,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFFlush,
    output logic [15:0] StallCount
);

    typedef enum logic {
        IDLE   = 1'b0,
        STALL2 = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_load;
    logic br_alu;
    logic br_mem;
    logic stall_raw;
    logic stall;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    always_comb begin
        ex_match  = reg_match(EX_WriteReg, ID_Rs, ID_Rt, ID_UsesRt);
        mem_match = reg_match(MEM_WriteReg, ID_Rs, ID_Rt, ID_UsesRt);
        load_use  = EX_MemRead && ex_match;
        br_load   = ID_Branch && load_use;
        br_alu    = ID_Branch && EX_RegWrite && !EX_MemRead && ex_match;
        br_mem    = ID_Branch && MEM_MemRead && mem_match;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A branch behind a load needs the loaded value two stages later, hence STALL2.
    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                stall_raw = load_use || br_alu || br_mem;
                if (br_load) begin
                    state_nxt = STALL2;
                end
            end
            STALL2: begin
                stall_raw = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                stall_raw = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall     = Rst && stall_raw;
    assign HazardSel = stall;
    assign PCWrite   = !stall;
    assign IFIDWrite = !stall;
    // The branch re-resolves after the stall, so the flush is deferred, never lost.
    assign IFFlush   = Rst && ID_Taken && !stall;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed scenarios plus randomized run vs a stall-budget model.
module tb_hazard_detect_unit;

    logic        Clk;
    logic        Rst;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        ID_Branch;
    logic        ID_Taken;
    logic        EX_MemRead;
    logic        EX_RegWrite;
    logic [4:0]  EX_WriteReg;
    logic        MEM_MemRead;
    logic [4:0]  MEM_WriteReg;
    logic        HazardSel;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFFlush;
    logic [15:0] StallCount;
    logic [3:0]  obs;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [3:0] V_STALL  = 4'b1000;
    localparam logic [3:0] V_NORMAL = 4'b0110;
    localparam logic [3:0] V_FLUSH  = 4'b0111;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_detect_unit dut (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_Taken(ID_Taken), .EX_MemRead(EX_MemRead),
        .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead),
        .MEM_WriteReg(MEM_WriteReg), .HazardSel(HazardSel), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IFFlush(IFFlush), .StallCount(StallCount)
    );

    assign obs = {HazardSel, PCWrite, IFIDWrite, IFFlush};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] exp_cnt(input int c);
        return STATS ? 16'(c) : 16'd0;
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic br, input logic tk, input logic exmr, input logic exrw,
                          input logic [4:0] exwr, input logic memmr, input logic [4:0] memwr);
        ID_Rs = rs; ID_Rt = rt; ID_UsesRt = urt; ID_Branch = br; ID_Taken = tk;
        EX_MemRead = exmr; EX_RegWrite = exrw; EX_WriteReg = exwr;
        MEM_MemRead = memmr; MEM_WriteReg = memwr;
    endtask

    task automatic quiet();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        next();
        Rst = 1'b0;
        quiet();
        #2;
        Rst = 1'b1;
    endtask

    // Reference: stall length needed by the ID instruction, longest hazard wins.
    function automatic int need_cycles();
        bit ex_hit;
        bit mem_hit;
        int n;
        ex_hit  = (EX_WriteReg != 0) && ((EX_WriteReg == ID_Rs) || (ID_UsesRt && EX_WriteReg == ID_Rt));
        mem_hit = (MEM_WriteReg != 0) && ((MEM_WriteReg == ID_Rs) || (ID_UsesRt && MEM_WriteReg == ID_Rt));
        n = 0;
        if (EX_MemRead && ex_hit) n = 1;
        if (ID_Branch && EX_RegWrite && !EX_MemRead && ex_hit && n < 1) n = 1;
        if (ID_Branch && MEM_MemRead && mem_hit && n < 1) n = 1;
        if (ID_Branch && EX_MemRead && ex_hit) n = 2;
        return n;
    endfunction

    task automatic test_reset();
        next();
        Rst = 1'b0;
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, V_NORMAL);
        end
        n_tests++;
        if (StallCount !== 16'd0) begin
            n_fail++; $display("FAIL reset_count got=%h exp=0", StallCount);
        end
        Rst = 1'b1;
        quiet();
    endtask

    task automatic test_load_use();
        do_reset();
        next();
        set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL load_use_stall got=%b exp=%b", obs, V_STALL);
        end
        next();
        quiet();
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL load_use_release got=%b exp=%b", obs, V_NORMAL);
        end
        n_tests++;
        if (StallCount !== exp_cnt(1)) begin
            n_fail++; $display("FAIL load_use_count got=%h exp=%h", StallCount, exp_cnt(1));
        end
    endtask

    task automatic test_branch_load();
        do_reset();
        next();
        set_in(5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL br_load_first got=%b exp=%b", obs, V_STALL);
        end
        next();
        quiet();
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL br_load_stall2 got=%b exp=%b", obs, V_STALL);
        end
        next();
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL br_load_release got=%b exp=%b", obs, V_NORMAL);
        end
        n_tests++;
        if (StallCount !== exp_cnt(2)) begin
            n_fail++; $display("FAIL br_load_count got=%h exp=%h", StallCount, exp_cnt(2));
        end
    endtask

    task automatic test_zero_and_unused();
        do_reset();
        next();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL zero_reg got=%b exp=%b", obs, V_NORMAL);
        end
        next();
        set_in(5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9);
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL unused_rt got=%b exp=%b", obs, V_NORMAL);
        end
    endtask

    task automatic test_branch_one_cycle();
        do_reset();
        next();
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL br_alu_stall got=%b exp=%b", obs, V_STALL);
        end
        next();
        set_in(5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL br_mem_stall got=%b exp=%b", obs, V_STALL);
        end
        next();
        quiet();
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL br_one_release got=%b exp=%b", obs, V_NORMAL);
        end
    endtask

    task automatic test_priority();
        do_reset();
        next();
        set_in(5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 5'd7);
        #3;
        next();
        quiet();
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL priority_two_cycle got=%b exp=%b", obs, V_STALL);
        end
    endtask

    task automatic test_flush();
        do_reset();
        next();
        set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL flush_suppressed got=%b exp=%b", obs, V_STALL);
        end
        next();
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        #3;
        n_tests++;
        if (obs !== V_FLUSH) begin
            n_fail++; $display("FAIL flush_after_stall got=%b exp=%b", obs, V_FLUSH);
        end
        next();
        quiet();
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL flush_one_cycle got=%b exp=%b", obs, V_NORMAL);
        end
    endtask

    task automatic test_reset_in_stall2();
        do_reset();
        next();
        set_in(5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        next();
        quiet();
        #1;
        n_tests++;
        if (obs !== V_STALL) begin
            n_fail++; $display("FAIL rst_stall2_entered got=%b exp=%b", obs, V_STALL);
        end
        Rst = 1'b0;
        #1;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL rst_stall2_immediate got=%b exp=%b", obs, V_NORMAL);
        end
        #1;
        Rst = 1'b1;
        next();
        #3;
        n_tests++;
        if (obs !== V_NORMAL) begin
            n_fail++; $display("FAIL rst_stall2_abandon got=%b exp=%b", obs, V_NORMAL);
        end
        n_tests++;
        if (StallCount !== 16'd0) begin
            n_fail++; $display("FAIL rst_stall2_count got=%h exp=0", StallCount);
        end
    endtask

    task automatic test_random();
        int pend;
        int cnt;
        int need;
        bit es;
        bit ef;
        logic [3:0] ev;
        do_reset();
        pend = 0;
        cnt  = 0;
        for (int i = 0; i < 400; i++) begin
            next();
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
            #3;
            if (pend > 0) begin
                es = 1'b1;
                pend--;
            end else begin
                need = need_cycles();
                es = (need > 0);
                pend = (need > 0) ? need - 1 : 0;
            end
            ef = ID_Taken && !es;
            ev = {es, !es, !es, ef};
            n_tests++;
            if (obs !== ev) begin
                n_fail++; $display("FAIL random_outputs cyc=%0d got=%b exp=%b", i, obs, ev);
            end
            n_tests++;
            if (StallCount !== exp_cnt(cnt)) begin
                n_fail++; $display("FAIL random_count cyc=%0d got=%h exp=%h", i, StallCount, exp_cnt(cnt));
            end
            n_tests++;
            if ((HazardSel && IFFlush) !== 1'b0) begin
                n_fail++; $display("FAIL random_exclusive cyc=%0d sel=%b flush=%b exp=not both", i, HazardSel, IFFlush);
            end
            if (es && cnt < 65535) cnt++;
        end
        quiet();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_saturation();
        do_reset();
        next();
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        n_tests++;
        if (StallCount !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_preload got=%h exp=fffe", StallCount);
        end
        for (int i = 0; i < 3; i++) begin
            next();
            #3;
            n_tests++;
            if (StallCount !== 16'hFFFF) begin
                n_fail++; $display("FAIL sat_hold step=%0d got=%h exp=ffff", i, StallCount);
            end
        end
        quiet();
    endtask
`endif

    initial begin
        Rst = 1'b0;
        quiet();
        test_reset();
        test_load_use();
        test_branch_load();
        test_zero_and_unused();
        test_branch_one_cycle();
        test_priority();
        test_flush();
        test_reset_in_stall2();
        test_random();
`ifdef HAZARD_STATS_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
